uart_rx_cfg: RTL and testbench

- Parametrised successor to the team's fixed 8N1 AXI4-Stream UART receiver.
- Adds a configurable word width and runtime-selectable parity and stop bits.
- Adds a 2-flop input synchroniser, 3-sample majority-vote bit sampling, and parity and break detection.
- Sits between the pad-side rxd line and a byte-stream consumer (FIFO or bridge) with an AXI4-Stream master output.

---
 rtl/uart_rx_cfg.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5..9 data bits, none/even/odd parity, 1 or 2 stop bits)
//   with an AXI4-Stream master output. Latency: word appears one cycle after the final stop-bit evaluation.
// Backpressure: a single output register; a new word overwrites an unaccepted one and flags overrun_error.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   rxd                 - asynchronous serial line, idle high
//   m_axis_t*           - received word stream (tdata LSB-justified)
//   busy                - frame in progress (start detected until return to idle)
//   *_error             - one-cycle status pulses: overrun, frame, parity, break
//   parity_mode         - 0/3 none, 1 even, 2 odd; stop_bits 0 = one, 1 = two
//   prescale            - bit period = 8*prescale clocks; 0 disables the receiver
module uart_rx_cfg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  break_error,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  input  logic [15:0]           prescale
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK_WAIT
  } state_t;

  state_t                r_state;
  logic [1:0]            r_sync;
  logic [2:0]            r_samp;
  logic [18:0]           r_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [3:0]            r_bitcnt;
  logic                  r_par_bit;
  logic                  r_stop1;
  logic [1:0]            r_cfg_parity;
  logic                  r_cfg_stop2;
  logic [15:0]           r_cfg_prescale;

  logic        w_rxd_s;
  logic        w_vote;
  logic        w_tick;
  logic        w_par_en;
  logic [18:0] w_bit_load;
  logic [18:0] w_half_load;
  logic        w_final_stop;
  logic        w_stops_ok;
  logic        w_is_break;
  logic        w_par_err;

  assign w_rxd_s  = r_sync[1];
  assign w_vote   = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
  assign w_tick   = (r_cnt == 19'd0);
  assign w_par_en = (r_cfg_parity == 2'd1) || (r_cfg_parity == 2'd2);

  // Full bit uses the latched prescale; the half-bit load happens in the
  // same cycle the configuration is latched, so it uses the live input.
  assign w_bit_load  = {r_cfg_prescale, 3'b000} - 19'd1;
  assign w_half_load = {1'b0, prescale, 2'b00} - 19'd1;

  // Completion is the last stop evaluation of the frame.
  assign w_final_stop = w_tick && (((r_state == S_STOP1) && !r_cfg_stop2) || (r_state == S_STOP2));
  assign w_stops_ok   = w_vote && ((r_state == S_STOP2) ? r_stop1 : 1'b1);
  assign w_is_break   = (r_data == '0) && !(w_par_en && r_par_bit) && !w_stops_ok;
  // Even: data ^ parity must be 0; odd: must be 1.
  assign w_par_err    = w_par_en && ((^r_data ^ r_par_bit) != (r_cfg_parity == 2'd2));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_sync         <= 2'b11;
      r_samp         <= 3'b111;
      r_cnt          <= '0;
      r_data         <= '0;
      r_bitcnt       <= '0;
      r_par_bit      <= 1'b0;
      r_stop1        <= 1'b1;
      r_cfg_parity   <= '0;
      r_cfg_stop2    <= 1'b0;
      r_cfg_prescale <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
      busy           <= 1'b0;
      overrun_error  <= 1'b0;
      frame_error    <= 1'b0;
      parity_error   <= 1'b0;
      break_error    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_samp <= {r_samp[1:0], r_sync[1]};

      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      break_error   <= 1'b0;

      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      if (!w_tick) begin
        r_cnt <= r_cnt - 19'd1;
      end

      case (r_state)
        S_IDLE: begin
          if ((prescale != 16'd0) && !w_rxd_s) begin
            r_cfg_parity   <= parity_mode;
            r_cfg_stop2    <= stop_bits;
            r_cfg_prescale <= prescale;
            r_cnt          <= w_half_load;
            r_data         <= '0;
            r_bitcnt       <= '0;
            r_par_bit      <= 1'b0;
            r_stop1        <= 1'b1;
            busy           <= 1'b1;
            r_state        <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_vote) begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= w_bit_load;
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_data   <= {w_vote, r_data[DATA_WIDTH-1:1]};
            r_cnt    <= w_bit_load;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'(DATA_WIDTH - 1)) begin
              r_state <= w_par_en ? S_PARITY : S_STOP1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par_bit <= w_vote;
            r_cnt     <= w_bit_load;
            r_state   <= S_STOP1;
          end
        end
        S_STOP1: begin
          // Single-stop completion is handled below with w_final_stop.
          if (w_tick && r_cfg_stop2) begin
            r_stop1 <= w_vote;
            r_cnt   <= w_bit_load;
            r_state <= S_STOP2;
          end
        end
        S_STOP2: begin
          // Completion only; handled below.
        end
        S_BREAK_WAIT: begin
          if (w_rxd_s) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase

      if (w_final_stop) begin
        if (w_is_break) begin
          break_error <= 1'b1;
          r_state     <= S_BREAK_WAIT;
        end else if (!w_stops_ok) begin
          frame_error <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end else begin
          m_axis_tdata  <= r_data;
          m_axis_tvalid <= 1'b1;
          parity_error  <= w_par_err;
          // A handshake in this same cycle frees the slot, so no overrun.
          overrun_error <= m_axis_tvalid && !m_axis_tready;
          busy          <= 1'b0;
          r_state       <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed vectors for uart_rx_cfg (8-bit and 7-bit instances).
// Stimulus is driven #1 after the rising edge; pulses are counted on the falling edge.
// Expected values are hand-computed per vector.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        tready;
  logic        stop_bits;
  logic [1:0]  parity_mode;
  logic [15:0] prescale;

  logic [7:0] tdata8;
  logic       tvalid8, busy8, oe8, fe8, pe8, be8;
  logic [6:0] tdata7;
  logic       tvalid7, busy7, oe7, fe7, pe7, be7;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready),
    .rxd(rxd), .busy(busy8),
    .overrun_error(oe8), .frame_error(fe8), .parity_error(pe8), .break_error(be8),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .prescale(prescale)
  );

  uart_rx_cfg #(.DATA_WIDTH(7)) dut7 (
    .clk(clk), .rst(rst),
    .m_axis_tdata(tdata7), .m_axis_tvalid(tvalid7), .m_axis_tready(tready),
    .rxd(rxd), .busy(busy7),
    .overrun_error(oe7), .frame_error(fe7), .parity_error(pe7), .break_error(be7),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .prescale(prescale)
  );

  // Event counters, only ever incremented here; tests work with deltas.
  int xf8 = 0, pc8 = 0, fc8 = 0, bc8 = 0, oc8 = 0, last8 = 0;
  int xf7 = 0, pc7 = 0, fc7 = 0, bc7 = 0, oc7 = 0, last7 = 0;

  always @(negedge clk) begin
    if (tvalid8 && tready) begin xf8++; last8 = int'(tdata8); end
    if (pe8) pc8++;
    if (fe8) fc8++;
    if (be8) bc8++;
    if (oe8) oc8++;
    if (tvalid7 && tready) begin xf7++; last7 = int'(tdata7); end
    if (pe7) pc7++;
    if (fe7) fc7++;
    if (be7) bc7++;
    if (oe7) oc7++;
  end

  int total = 0;
  int bad   = 0;
  int b_xf, b_pc, b_fc, b_bc, b_oc;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap8();
    b_xf = xf8; b_pc = pc8; b_fc = fc8; b_bc = bc8; b_oc = oc8;
  endtask

  task automatic snap7();
    b_xf = xf7; b_pc = pc7; b_fc = fc7; b_bc = bc7; b_oc = oc7;
  endtask

  // One bit cell of 8*p clocks; gl >= 0 inverts the line for one clock at that offset.
  task automatic drive_bit(input logic v, input int p, input int gl);
    for (int c = 0; c < 8 * p; c++) begin
      rxd = (c == gl) ? ~v : v;
      tick(1);
    end
  endtask

  // A low stop bit is held only over its first half so the line is high
  // again before the receiver looks for the next start edge.
  task automatic drive_stop(input logic v, input int p);
    if (v) begin
      drive_bit(1'b1, p, -1);
    end else begin
      rxd = 1'b0;
      tick(4 * p);
      rxd = 1'b1;
      tick(4 * p);
    end
  endtask

  task automatic send_frame(input logic [8:0] data, input int w, input logic has_par,
                            input logic pbit, input int nstop, input logic st1,
                            input logic st2, input int p, input int gl_bit);
    logic [8:0] d;
    d = data;
    drive_bit(1'b0, p, -1);
    for (int i = 0; i < w; i++) drive_bit(d[i], p, (i == gl_bit) ? 4 * p - 2 : -1);
    if (has_par) drive_bit(pbit, p, -1);
    drive_stop(st1, p);
    if (nstop == 2) drive_stop(st2, p);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [8:0] data;
    logic [1:0] pm;
    logic       pbit;
    logic       sb;
    logic       st1;
    logic       st2;
    int         p;
    int         gl;
    int         e_xf;
    int         e_data;
    int         e_pe;
    int         e_fe;
    int         e_be;
  } vec_t;

  vec_t vt [11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          data    pm    pb    sb    st1   st2   p  gl  xf data  pe fe be
    vt[0]  = '{9'h0A5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1, 'hA5, 0, 0, 0};
    vt[1]  = '{9'h037, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1, 'h37, 1, 0, 0};
    vt[2]  = '{9'h037, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1, -1, 1, 'h37, 0, 0, 0};
    vt[3]  = '{9'h037, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1, 'h37, 0, 0, 0};
    vt[4]  = '{9'h000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2, -1, 1, 'h00, 0, 0, 0};
    vt[5]  = '{9'h0FF, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1, -1, 1, 'hFF, 0, 0, 0};
    vt[6]  = '{9'h05A, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 3, -1, 1, 'h5A, 0, 0, 0};
    vt[7]  = '{9'h096, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 4,  3, 1, 'h96, 0, 0, 0};
    vt[8]  = '{9'h080, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1, -1, 0, 'h00, 0, 1, 0};
    vt[9]  = '{9'h000, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1, -1, 0, 'h00, 0, 1, 0};
    vt[10] = '{9'h000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1, -1, 0, 'h00, 0, 0, 1};

    rst = 1'b1; rxd = 1'b1; tready = 1'b1;
    parity_mode = 2'd0; stop_bits = 1'b0; prescale = 16'd1;
    tick(3);
    check("reset_tvalid", int'(tvalid8), 0);
    check("reset_tdata", int'(tdata8), 0);
    check("reset_busy", int'(busy8), 0);
    check("reset_pulses", int'({oe8, fe8, pe8, be8}), 0);
    rst = 1'b0;
    tick(4);

    // Table-driven frames on the 8-bit instance.
    for (int k = 0; k < 11; k++) begin
      parity_mode = vt[k].pm;
      stop_bits   = vt[k].sb;
      prescale    = 16'(vt[k].p);
      snap8();
      send_frame(vt[k].data, 8, (vt[k].pm == 2'd1) || (vt[k].pm == 2'd2), vt[k].pbit,
                 vt[k].sb ? 2 : 1, vt[k].st1, vt[k].st2, vt[k].p, vt[k].gl);
      tick(16 * vt[k].p + 8);
      check($sformatf("v%0d_xfer", k), xf8 - b_xf, vt[k].e_xf);
      if (vt[k].e_xf > 0) check($sformatf("v%0d_data", k), last8, vt[k].e_data);
      check($sformatf("v%0d_perr", k), pc8 - b_pc, vt[k].e_pe);
      check($sformatf("v%0d_ferr", k), fc8 - b_fc, vt[k].e_fe);
      check($sformatf("v%0d_brk", k), bc8 - b_bc, vt[k].e_be);
      check($sformatf("v%0d_ovr", k), oc8 - b_oc, 0);
      check($sformatf("v%0d_busy", k), int'(busy8), 0);
    end

    // Receiver disabled: a low line is ignored.
    prescale = 16'd0;
    snap8();
    rxd = 1'b0;
    tick(10);
    check("disabled_busy", int'(busy8), 0);
    rxd = 1'b1;
    tick(10);
    check("disabled_xfer", xf8 - b_xf, 0);

    // False start at prescale 4: busy rises, drops exactly at the start evaluation.
    prescale = 16'd4; parity_mode = 2'd0; stop_bits = 1'b0;
    snap8();
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(2);
    check("fstart_busy_on", int'(busy8), 1);
    tick(14);
    check("fstart_busy_pre_eval", int'(busy8), 1);
    tick(1);
    check("fstart_busy_off", int'(busy8), 0);
    tick(20);
    check("fstart_xfer", xf8 - b_xf, 0);
    check("fstart_pulses", (pc8 - b_pc) + (fc8 - b_fc) + (bc8 - b_bc), 0);

    // Break: line low for 12 bit periods.
    prescale = 16'd1;
    snap8();
    rxd = 1'b0;
    tick(96);
    check("break_busy_held", int'(busy8), 1);
    check("break_pulse", bc8 - b_bc, 1);
    rxd = 1'b1;
    tick(6);
    check("break_busy_rel", int'(busy8), 0);
    check("break_xfer", xf8 - b_xf, 0);
    check("break_ferr", fc8 - b_fc, 0);
    check("break_pulse_once", bc8 - b_bc, 1);
    tick(10);

    // Overrun: two words with no consumer, then drain.
    tready = 1'b0;
    snap8();
    send_frame(9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1, -1);
    tick(5);
    check("ovr_first_valid", int'(tvalid8), 1);
    check("ovr_first_data", int'(tdata8), 'h11);
    send_frame(9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1, -1);
    tick(5);
    check("ovr_pulse", oc8 - b_oc, 1);
    check("ovr_second_data", int'(tdata8), 'h22);
    tready = 1'b1;
    tick(3);
    check("ovr_drain_xfer", xf8 - b_xf, 1);
    check("ovr_drain_data", last8, 'h22);
    check("ovr_drain_valid", int'(tvalid8), 0);

    // 7-bit instance, two stop bits.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(4);
    stop_bits = 1'b1; parity_mode = 2'd0; prescale = 16'd1; tready = 1'b0;
    snap7();
    send_frame(9'h02A, 7, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1, -1);
    tick(5);
    check("w7_hold_valid", int'(tvalid7), 1);
    check("w7_hold_data", int'(tdata7), 'h2A);
    send_frame(9'h055, 7, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1, -1);
    tick(10);
    check("w7_ferr", fc7 - b_fc, 1);
    check("w7_ferr_nodrop", int'(tdata7), 'h2A);
    check("w7_ferr_novr", oc7 - b_oc, 0);

    // Reset in the middle of the data bits of 0x13.
    drive_bit(1'b0, 1, -1);
    drive_bit(1'b1, 1, -1);
    drive_bit(1'b1, 1, -1);
    check("w7_busy_mid", int'(busy7), 1);
    rxd = 1'b1;
    rst = 1'b1;
    tick(1);
    check("w7_rst_busy", int'(busy7), 0);
    check("w7_rst_valid", int'(tvalid7), 0);
    check("w7_rst_data", int'(tdata7), 0);
    rst = 1'b0;
    tick(20);
    tready = 1'b1;
    snap7();
    send_frame(9'h02A, 7, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1, -1);
    tick(10);
    check("w7_after_rst_xfer", xf7 - b_xf, 1);
    check("w7_after_rst_data", last7, 'h2A);
    check("w7_after_rst_busy", int'(busy7), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
